sensor_interface_array: RTL and testbench

//  Multi-lane successor of the single-lane vehicle/pedestrian sensor front end.

---
 rtl/sensor_interface_array.sv | 144 ++++++++++++++
 tb/tb_sensor_interface_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_interface_array.sv
// Multi-lane vehicle/pedestrian sensor front end: synchronise, debounce, count arrivals, latch ped requests.
// Optional stuck-sensor detection is built when STUCK_DETECT_EN is defined.
module sensor_interface_array #(
  parameter int N_VEH        = 4,
  parameter int N_PED        = 2,
  parameter int DEB_CYCLES   = 8,
  parameter int CNT_W        = 8,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_VEH-1:0]         i_vehicle_sensor,
  input  logic [N_PED-1:0]         i_ped_sensor,
  input  logic [N_PED-1:0]         i_ped_clear,
  input  logic                     i_count_clear,
  output logic [N_VEH-1:0]         o_vehicle_detected,
  output logic [N_VEH-1:0]         o_vehicle_arrival,
  output logic [N_VEH*CNT_W-1:0]   o_vehicle_count,
  output logic [N_PED-1:0]         o_ped_detected,
  output logic [N_PED-1:0]         o_ped_request,
  output logic                     o_any_vehicle,
  output logic                     o_any_ped_request,
  output logic [N_VEH-1:0]         o_sensor_fault
);

  localparam int N_CH = N_VEH + N_PED;
  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  if (N_VEH < 1 || N_PED < 1 || DEB_CYCLES < 1 || CNT_W < 1 || STUCK_CYCLES < 1) begin : g_bad_params
    $error("sensor_interface_array: invalid parameter value");
  end

  // Vehicle lanes occupy the low channel indices, pedestrian buttons the high ones.
  logic [N_CH-1:0]          w_raw;
  logic [N_CH-1:0]          r_sync1;
  logic [N_CH-1:0]          r_sync2;
  logic [N_CH-1:0]          r_state;
  logic [N_CH-1:0][DW-1:0]  r_deb_cnt;
  logic [N_CH-1:0]          w_flip;
  logic [N_VEH-1:0]         w_veh_rise;
  logic [N_PED-1:0]         w_ped_rise;

  assign w_raw = {i_ped_sensor, i_vehicle_sensor};

  always_comb begin
    w_flip = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      w_flip[ch] = (r_sync2[ch] != r_state[ch]) && (r_deb_cnt[ch] == DEB_LAST);
    end
  end

  assign w_veh_rise = w_flip[N_VEH-1:0] & ~r_state[N_VEH-1:0];
  assign w_ped_rise = w_flip[N_CH-1:N_VEH] & ~r_state[N_CH-1:N_VEH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_state <= r_state ^ w_flip;
      for (int ch = 0; ch < N_CH; ch++) begin
        if ((r_sync2[ch] == r_state[ch]) || w_flip[ch]) begin
          r_deb_cnt[ch] <= '0;
        end else begin
          r_deb_cnt[ch] <= r_deb_cnt[ch] + DW'(1);
        end
      end
    end
  end

  logic [N_VEH-1:0]             r_arrival;
  logic [N_VEH-1:0][CNT_W-1:0]  r_count;
  logic [N_PED-1:0]             r_request;

  // A clear coinciding with an arrival keeps that arrival, so the lane restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arrival <= '0;
      r_count   <= '0;
      r_request <= '0;
    end else begin
      r_arrival <= w_veh_rise;
      r_request <= w_ped_rise | (r_request & ~i_ped_clear);
      for (int i = 0; i < N_VEH; i++) begin
        if (i_count_clear) begin
          r_count[i] <= CNT_W'(w_veh_rise[i]);
        end else if (w_veh_rise[i] && (r_count[i] != '1)) begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

  logic [N_VEH-1:0]           w_veh_fall;
  logic [N_VEH-1:0][SW-1:0]   r_stuck_cnt;
  logic [N_VEH-1:0]           r_fault;

  assign w_veh_fall = w_flip[N_VEH-1:0] & r_state[N_VEH-1:0];

  // The fault drops on the same edge the debounced level falls, not one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stuck_cnt <= '0;
      r_fault     <= '0;
    end else begin
      for (int i = 0; i < N_VEH; i++) begin
        if (!r_state[i] || w_veh_fall[i]) begin
          r_stuck_cnt[i] <= '0;
          r_fault[i]     <= 1'b0;
        end else begin
          if (r_stuck_cnt[i] != STUCK_MAX) begin
            r_stuck_cnt[i] <= r_stuck_cnt[i] + SW'(1);
          end
          if (r_stuck_cnt[i] == STUCK_MAX - SW'(1)) begin
            r_fault[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_sensor_fault = r_fault;
`else
  assign o_sensor_fault = '0;
`endif

  assign o_vehicle_detected = r_state[N_VEH-1:0];
  assign o_ped_detected     = r_state[N_CH-1:N_VEH];
  assign o_vehicle_arrival  = r_arrival;
  assign o_vehicle_count    = r_count;
  assign o_ped_request      = r_request;
  assign o_any_vehicle      = |r_state[N_VEH-1:0];
  assign o_any_ped_request  = |r_request;

endmodule

// File: tb/tb_sensor_interface_array.sv
// Bench for sensor_interface_array: directed scenarios plus random toggling, checked against a
// sliding-window reference model of the debounce rules.
module tb_sensor_interface_array;

   localparam int NV  = 4;
   localparam int NP  = 2;
   localparam int DEB = 4;
   localparam int CW  = 3;
   localparam int STK = 20;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef STUCK_DETECT_EN
   localparam bit STUCK_ON = 1'b1;
`else
   localparam bit STUCK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic [NV-1:0] vehicleSensor;
   logic [NP-1:0] pedSensor;
   logic [NP-1:0] pedClear;
   logic countClear;
   logic [NV-1:0] vehicleDetected;
   logic [NV-1:0] vehicleArrival;
   logic [NV*CW-1:0] vehicleCount;
   logic [NP-1:0] pedDetected;
   logic [NP-1:0] pedRequest;
   logic anyVehicle;
   logic anyPedRequest;
   logic [NV-1:0] sensorFault;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model: raw samples per edge, newest at index 0.
   bit vHist [NV][DEB+2];
   bit pHist [NP][DEB+2];
   logic [NV-1:0] mDet, mArr, mFault;
   logic [NP-1:0] mPDet, mReq;
   int mCnt [NV];
   int mRun [NV];

   sensor_interface_array #(
      .N_VEH(NV), .N_PED(NP), .DEB_CYCLES(DEB), .CNT_W(CW), .STUCK_CYCLES(STK)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i_vehicle_sensor(vehicleSensor),
      .i_ped_sensor(pedSensor),
      .i_ped_clear(pedClear),
      .i_count_clear(countClear),
      .o_vehicle_detected(vehicleDetected),
      .o_vehicle_arrival(vehicleArrival),
      .o_vehicle_count(vehicleCount),
      .o_ped_detected(pedDetected),
      .o_ped_request(pedRequest),
      .o_any_vehicle(anyVehicle),
      .o_any_ped_request(anyPedRequest),
      .o_sensor_fault(sensorFault)
   );

   always #5 clk = ~clk;

   // Clears everything the model knows, mirroring loss of state on reset.
   task automatic modelReset();
      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < DEB+2; k++) vHist[i][k] = 1'b0;
         mCnt[i] = 0;
         mRun[i] = 0;
      end
      for (int j = 0; j < NP; j++) begin
         for (int k = 0; k < DEB+2; k++) pHist[j][k] = 1'b0;
      end
      mDet = '0; mArr = '0; mFault = '0; mPDet = '0; mReq = '0;
   endtask

   // A level flips once the DEB raw samples taken 2..DEB+1 edges ago all disagree with it.
   task automatic modelEdge();
      bit flip;
      if (!reset_n) begin
         modelReset();
         return;
      end
      for (int i = 0; i < NV; i++) begin
         for (int k = DEB+1; k > 0; k--) vHist[i][k] = vHist[i][k-1];
         vHist[i][0] = vehicleSensor[i];
         flip = 1'b1;
         for (int k = 2; k <= DEB+1; k++) if (vHist[i][k] == mDet[i]) flip = 1'b0;
         mArr[i] = flip && !mDet[i];
         if (flip) mDet[i] = !mDet[i];
         if (countClear) mCnt[i] = mArr[i] ? 1 : 0;
         else if (mArr[i] && mCnt[i] < CNT_MAX) mCnt[i] = mCnt[i] + 1;
         mRun[i] = mDet[i] ? mRun[i] + 1 : 0;
         mFault[i] = STUCK_ON && mDet[i] && (mRun[i] > STK);
      end
      for (int j = 0; j < NP; j++) begin
         for (int k = DEB+1; k > 0; k--) pHist[j][k] = pHist[j][k-1];
         pHist[j][0] = pedSensor[j];
         flip = 1'b1;
         for (int k = 2; k <= DEB+1; k++) if (pHist[j][k] == mPDet[j]) flip = 1'b0;
         if (flip) mPDet[j] = !mPDet[j];
         if (flip && mPDet[j]) mReq[j] = 1'b1;
         else if (pedClear[j]) mReq[j] = 1'b0;
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compares every output against the reference model.
   task automatic checkOutput();
      logic [NV*CW-1:0] expCnt;
      for (int i = 0; i < NV; i++) expCnt[i*CW +: CW] = CW'(mCnt[i]);
      checkVal("vehicle_detected", vehicleDetected, mDet);
      checkVal("vehicle_arrival", vehicleArrival, mArr);
      checkVal("vehicle_count", vehicleCount, expCnt);
      checkVal("ped_detected", pedDetected, mPDet);
      checkVal("ped_request", pedRequest, mReq);
      checkVal("any_vehicle", anyVehicle, |mDet);
      checkVal("any_ped_request", anyPedRequest, |mReq);
      checkVal("sensor_fault", sensorFault, mFault);
   endtask

   // Advances the given number of edges; inputs change only 1 time unit after an edge.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         modelEdge();
         #1;
         checkOutput();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      vehicleSensor = '0; pedSensor = '0; pedClear = '0; countClear = 1'b0;
      modelReset();
      applyStimulus(2);
      reset_n = 1'b1;
      applyStimulus(2);

      // Latency on lane 2, both directions.
      vehicleSensor[2] = 1'b1;
      applyStimulus(5);
      checkVal("lat_rise_edge5", vehicleDetected[2], 1'b0);
      applyStimulus(1);
      checkVal("lat_rise_edge6", vehicleDetected[2], 1'b1);
      checkVal("lat_arrival", vehicleArrival[2], 1'b1);
      checkVal("lat_count", vehicleCount[2*CW +: CW], 3'd1);
      applyStimulus(1);
      checkVal("lat_arrival_one_cycle", vehicleArrival[2], 1'b0);
      vehicleSensor[2] = 1'b0;
      applyStimulus(5);
      checkVal("lat_fall_edge5", vehicleDetected[2], 1'b1);
      applyStimulus(1);
      checkVal("lat_fall_edge6", vehicleDetected[2], 1'b0);

      // Glitchy lane 0 never qualifies.
      vehicleSensor[0] = 1'b1; applyStimulus(3);
      vehicleSensor[0] = 1'b0; applyStimulus(1);
      vehicleSensor[0] = 1'b1; applyStimulus(3);
      vehicleSensor[0] = 1'b0; applyStimulus(8);
      checkVal("glitch_det", vehicleDetected[0], 1'b0);
      checkVal("glitch_count", vehicleCount[0 +: CW], 3'd0);

      // Saturation on lane 1, then clear coinciding with an arrival.
      for (int n = 0; n < 9; n++) begin
         vehicleSensor[1] = 1'b1; applyStimulus(7);
         vehicleSensor[1] = 1'b0; applyStimulus(7);
      end
      checkVal("sat_count", vehicleCount[1*CW +: CW], 3'd7);
      vehicleSensor[1] = 1'b1; applyStimulus(5);
      countClear = 1'b1; applyStimulus(1);
      countClear = 1'b0;
      checkVal("clear_arrival", vehicleArrival[1], 1'b1);
      checkVal("clear_count", vehicleCount[1*CW +: CW], 3'd1);
      vehicleSensor[1] = 1'b0; applyStimulus(7);

      // Pedestrian handshake on button 1.
      pedSensor[1] = 1'b1; applyStimulus(6);
      checkVal("ped_set", pedRequest[1], 1'b1);
      checkVal("ped_any", anyPedRequest, 1'b1);
      pedClear[1] = 1'b1; applyStimulus(1);
      pedClear[1] = 1'b0;
      checkVal("ped_cleared", pedRequest[1], 1'b0);
      applyStimulus(4);
      checkVal("ped_held_no_reset", pedRequest[1], 1'b0);
      pedSensor[1] = 1'b0; applyStimulus(7);
      pedClear[1] = 1'b1; pedSensor[1] = 1'b1; applyStimulus(6);
      checkVal("ped_set_wins", pedRequest[1], 1'b1);
      applyStimulus(1);
      checkVal("ped_clear_after_set", pedRequest[1], 1'b0);
      pedClear[1] = 1'b0; pedSensor[1] = 1'b0; applyStimulus(7);

      // Stuck sensor on lane 3.
      vehicleSensor[3] = 1'b1; applyStimulus(6);
      applyStimulus(19);
      checkVal("stuck_before", sensorFault[3], 1'b0);
      applyStimulus(1);
      checkVal("stuck_set", sensorFault[3], STUCK_ON);
      vehicleSensor[3] = 1'b0; applyStimulus(5);
      checkVal("stuck_hold", sensorFault[3], STUCK_ON);
      applyStimulus(1);
      checkVal("stuck_clear", sensorFault[3], 1'b0);

      // Random toggling of all inputs.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NV; i++) if ($urandom_range(0, 5) == 0) vehicleSensor[i] = ~vehicleSensor[i];
         for (int j = 0; j < NP; j++) begin
            if ($urandom_range(0, 5) == 0) pedSensor[j] = ~pedSensor[j];
            pedClear[j] = ($urandom_range(0, 7) == 0);
         end
         countClear = ($urandom_range(0, 39) == 0);
         applyStimulus(1);
      end
      pedClear = '0; countClear = 1'b0;

      // Asynchronous reset mid-operation with every sensor held high.
      vehicleSensor = '1; pedSensor = '1;
      applyStimulus(8);
      #3;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkVal("reset_async_det", vehicleDetected, '0);
      checkVal("reset_async_req", pedRequest, '0);
      checkOutput();
      applyStimulus(2);
      reset_n = 1'b1;
      applyStimulus(5);
      checkVal("post_reset_edge5", vehicleDetected, '0);
      applyStimulus(1);
      checkVal("post_reset_det", vehicleDetected, 4'hF);
      checkVal("post_reset_arrival", vehicleArrival, 4'hF);
      checkVal("post_reset_count", vehicleCount, 12'h249);
      checkVal("post_reset_req", pedRequest, 2'b11);
      applyStimulus(3);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
